// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the fifo_512_40bit read-side controller.
package fifo_rd_pkg;
  localparam int RD_BUF_DEPTH = 4;
  localparam int RD_PTR_W     = 2;
  localparam int RD_CNT_W     = 3;
  localparam int RD_DW        = 40;

  typedef logic [RD_DW-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_512_40bit_reader_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the reader (master) or its environment (slave).
interface fifo_512_40bit_reader_if #(
  parameter int DW    = 40,
  parameter int CNT_W = 16
);
  logic             fifo_re;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_dout;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_ready;
  logic [CNT_W-1:0] words_out;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_re, m_valid, m_data, words_out
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_re, m_valid, m_data, words_out
  );
endinterface

// File: rtl/fifo_rd_buf.sv
// 4-entry circular skid buffer absorbing the FIFO's registered read latency.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DW = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [DW-1:0]       push_data_i,
  input  logic                pop_i,
  output logic [DW-1:0]       data_o,
  output logic [RD_CNT_W-1:0] cnt_o
);
  logic [DW-1:0]       buf_q [RD_BUF_DEPTH];
  logic [RD_PTR_W-1:0] wptr_q, rptr_q;
  logic [RD_CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous push and pop cancel out.
  always_comb begin
    cnt_d = cnt_q + RD_CNT_W'(push_i) - RD_CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) buf_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        buf_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign data_o = buf_q[rptr_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fifo_512_40bit_reader.sv
// Read-side controller for fifo_512_40bit: credit-based re, in-flight tracking, valid/ready output.
module fifo_512_40bit_reader
  import fifo_rd_pkg::*;
#(
  parameter int DW    = 40,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  fifo_512_40bit_reader_if.master bus
);
  logic                run_q;
  logic                inflight_q;
  logic                push, pop, m_valid;
  logic [RD_CNT_W-1:0] cnt;
  logic [RD_CNT_W:0]   credit;
  logic [CNT_W-1:0]    words_q, words_d;

  // Slots committed = buffered + in flight; re only from registered state, never from m_ready.
  assign credit  = {1'b0, cnt} + {{RD_CNT_W{1'b0}}, inflight_q};
  assign bus.fifo_re = run_q & ~bus.fifo_empty & ~clr
                     & (credit < (RD_CNT_W+1)'(RD_BUF_DEPTH));

  assign push    = inflight_q & ~clr;
  assign m_valid = (cnt != '0);
  assign pop     = m_valid & bus.m_ready;

  always_comb begin
    words_d = words_q;
    if (clr)      words_d = '0;
    else if (pop) words_d = words_q + 1'b1;
  end

  // run_q keeps re low while in reset and releases it on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= bus.fifo_re;
      words_q    <= words_d;
    end
  end

  fifo_rd_buf #(.DW(DW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clr),
    .push_i      (push),
    .push_data_i (bus.fifo_dout),
    .pop_i       (pop),
    .data_o      (bus.m_data),
    .cnt_o       (cnt)
  );

  assign bus.m_valid   = m_valid;
  assign bus.words_out = words_q;

  a_no_re_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.fifo_re && bus.fifo_empty));
  a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && cnt == RD_CNT_W'(RD_BUF_DEPTH)));
endmodule

// File: tb/tb_fifo_512_40bit_reader.sv
// Directed bench: behavioural FIFO model feeding two reader instances (16-bit and 4-bit word counters) in lockstep.
module tb_fifo_512_40bit_reader;
  import fifo_rd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       m_ready = 1'b0;
  logic       wr_en = 1'b0;
  fifo_word_t wr_data = '0;
  fifo_word_t fdout = '0;
  fifo_word_t fq[$];
  int         fcount = 0;
  logic       fempty;

  int         checks = 0;
  int         failures = 0;
  fifo_word_t next_val = 40'h00_0000_0001;
  fifo_word_t rxq[$];
  int         re_pulses = 0;
  int         re_empty_viol = 0;
  int         max_cnt = 0;

  fifo_512_40bit_reader_if #(.DW(40), .CNT_W(16)) ifa ();
  fifo_512_40bit_reader_if #(.DW(40), .CNT_W(4))  ifb ();

  assign fempty         = (fcount == 0);
  assign ifa.fifo_empty = fempty;
  assign ifa.fifo_dout  = fdout;
  assign ifa.m_ready    = m_ready;
  assign ifb.fifo_empty = fempty;
  assign ifb.fifo_dout  = fdout;
  assign ifb.m_ready    = m_ready;

  fifo_512_40bit_reader #(.DW(40), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa));
  fifo_512_40bit_reader #(.DW(40), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb));

  always #5 clk = ~clk;

  // FIFO model: combinational empty, dout registered on re, clr flushes; not reset by the reader's rst_n.
  always @(posedge clk) begin
    if (clr) fq.delete();
    else begin
      if (ifa.fifo_re && fq.size() != 0) fdout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fcount <= fq.size();
  end

  always @(posedge clk) begin
    if (rst_n && !clr && ifa.m_valid && m_ready) rxq.push_back(ifa.m_data);
    if (ifa.fifo_re) re_pulses <= re_pulses + 1;
    if (ifa.fifo_re && fempty) re_empty_viol <= re_empty_viol + 1;
    if (int'(dut_a.u_buf.cnt_q) > max_cnt) max_cnt <= int'(dut_a.u_buf.cnt_q);
  end

  task automatic do_clr();
    @(negedge clk);
    wr_en = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    next_val = 40'h00_0000_0001;
  endtask

  task automatic test_reset();
    int base;
    int n;
    int bad;
    logic re1, v1, v2, v3;
    fifo_word_t d3;
    rst_n = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = next_val; next_val++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (ifa.fifo_re !== 1'b0) begin failures++; $display("FAIL reset_fifo_re got=%0b exp=0", ifa.fifo_re); end
    checks++; if (ifa.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", ifa.m_valid); end
    checks++; if (ifa.words_out !== 16'd0) begin failures++; $display("FAIL reset_words_out got=%0d exp=0", ifa.words_out); end
    checks++; if (ifa.m_data !== 40'd0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", ifa.m_data); end
    rst_n = 1'b1;
    #1;
    checks++; if (ifa.fifo_re !== 1'b0) begin failures++; $display("FAIL release_cycle0_re got=%0b exp=0", ifa.fifo_re); end
    @(negedge clk); re1 = ifa.fifo_re; v1 = ifa.m_valid;
    @(negedge clk); v2 = ifa.m_valid;
    @(negedge clk); v3 = ifa.m_valid; d3 = ifa.m_data;
    checks++; if (re1 !== 1'b1) begin failures++; $display("FAIL release_cycle1_re got=%0b exp=1", re1); end
    checks++; if ({v1, v2, v3} !== 3'b001) begin failures++; $display("FAIL release_valid_c123 got=%b exp=001", {v1, v2, v3}); end
    checks++; if (d3 !== 40'h1) begin failures++; $display("FAIL release_first_data got=%h exp=1", d3); end
    base = rxq.size();
    m_ready = 1'b1;
    n = 0;
    while (rxq.size() - base < 3 && n < 20) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (rxq.size() <= base + i || rxq[base+i] !== fifo_word_t'(i + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_drain_data bad=%0d exp=0", bad); end
    checks++; if (ifa.words_out !== 16'd3) begin failures++; $display("FAIL reset_drain_words got=%0d exp=3", ifa.words_out); end
  endtask

  task automatic test_streaming();
    int first, run, maxrun, nvalid, bad;
    fifo_word_t expv;
    do_clr();
    m_ready = 1'b1;
    first = -1; run = 0; maxrun = 0; nvalid = 0; bad = 0; expv = 40'h1;
    for (int k = 0; k < 530; k++) begin
      @(negedge clk);
      if (ifa.m_valid) begin
        if (first < 0) first = k;
        nvalid++; run++;
        if (ifa.m_data !== expv) bad++;
        expv++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (k < 512) begin wr_en = 1'b1; wr_data = next_val; next_val++; end
      else wr_en = 1'b0;
    end
    checks++; if (first != 3) begin failures++; $display("FAIL stream_first_valid got=%0d exp=3", first); end
    checks++; if (maxrun != 512) begin failures++; $display("FAIL stream_valid_run got=%0d exp=512", maxrun); end
    checks++; if (nvalid != 512) begin failures++; $display("FAIL stream_valid_total got=%0d exp=512", nvalid); end
    checks++; if (bad != 0) begin failures++; $display("FAIL stream_data_order bad=%0d exp=0", bad); end
    checks++; if (ifa.words_out !== 16'd512) begin failures++; $display("FAIL stream_words_out got=%0d exp=512", ifa.words_out); end
  endtask

  task automatic test_backpressure();
    int r0, bad, base, n;
    do_clr();
    m_ready = 1'b0;
    r0 = re_pulses;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = next_val; next_val++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(ifa.m_valid === 1'b1 && ifa.m_data === 40'h1)) bad++;
    end
    checks++; if (re_pulses - r0 != 4) begin failures++; $display("FAIL bp_re_pulses got=%0d exp=4", re_pulses - r0); end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold_stable bad=%0d exp=0", bad); end
    base = rxq.size();
    m_ready = 1'b1;
    n = 0;
    while (rxq.size() - base < 10 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 10) begin failures++; $display("FAIL bp_drain_cycles got=%0d exp=10", n); end
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (rxq.size() <= base + i || rxq[base+i] !== fifo_word_t'(i + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_drain_data bad=%0d exp=0", bad); end
  endtask

  task automatic test_toggle_ready();
    int base, v0, pushed, n, bad;
    do_clr();
    base = rxq.size();
    v0 = re_empty_viol;
    pushed = 0; n = 0;
    while ((rxq.size() - base < 100) && n < 500) begin
      @(negedge clk);
      m_ready = n[0];
      if (pushed < 100) begin wr_en = 1'b1; wr_data = next_val; next_val++; pushed++; end
      else wr_en = 1'b0;
      n++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    m_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++)
      if (rxq.size() <= base + i || rxq[base+i] !== fifo_word_t'(i + 1)) bad++;
    checks++; if (rxq.size() - base != 100) begin failures++; $display("FAIL toggle_count got=%0d exp=100", rxq.size() - base); end
    checks++; if (bad != 0) begin failures++; $display("FAIL toggle_data bad=%0d exp=0", bad); end
    checks++; if (re_empty_viol != v0) begin failures++; $display("FAIL toggle_re_on_empty got=%0d exp=0", re_empty_viol - v0); end
    checks++; if (max_cnt > 4) begin failures++; $display("FAIL toggle_cnt_bound got=%0d exp<=4", max_cnt); end
    checks++; if (ifa.words_out !== 16'd100) begin failures++; $display("FAIL toggle_words_out got=%0d exp=100", ifa.words_out); end
  endtask

  task automatic test_clr_midstream();
    int n, base;
    logic found;
    fifo_word_t first_after;
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = next_val; next_val++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      if (dut_a.u_buf.cnt_q == 3'd3 && dut_a.inflight_q) found = 1'b1;
      n++;
    end
    checks++; if (found !== 1'b1 || ifa.m_valid !== 1'b1) begin failures++; $display("FAIL clr_setup got=%0b/%0b exp=1/1", found, ifa.m_valid); end
    clr = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (ifa.m_valid !== 1'b0) begin failures++; $display("FAIL clr_m_valid got=%0b exp=0", ifa.m_valid); end
    checks++; if (ifa.words_out !== 16'd0) begin failures++; $display("FAIL clr_words_out got=%0d exp=0", ifa.words_out); end
    base = rxq.size();
    first_after = 40'h00_0000_0ABC;
    wr_en = 1'b1; wr_data = first_after;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (rxq.size() == base && n < 20) begin @(negedge clk); n++; end
    checks++; if (rxq.size() <= base || rxq[base] !== first_after) begin failures++; $display("FAIL clr_next_word got=%h exp=%h", (rxq.size() > base) ? rxq[base] : 40'h0, first_after); end
    checks++; if (ifa.words_out !== 16'd1) begin failures++; $display("FAIL clr_words_after got=%0d exp=1", ifa.words_out); end
  endtask

  task automatic test_wrap_counter();
    int base, n, bad;
    do_clr();
    m_ready = 1'b1;
    base = rxq.size();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = next_val; next_val++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (rxq.size() - base < 20 && n < 60) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (rxq.size() <= base + i || rxq[base+i] !== fifo_word_t'(i + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_data bad=%0d exp=0", bad); end
    checks++; if (ifb.words_out !== 4'd4) begin failures++; $display("FAIL wrap_words_out_w4 got=%0d exp=4", ifb.words_out); end
    checks++; if (ifa.words_out !== 16'd20) begin failures++; $display("FAIL wrap_words_out_w16 got=%0d exp=20", ifa.words_out); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_toggle_ready();
    test_clr_midstream();
    test_wrap_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
